// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the PC redirect / return-address-stack block:
//   - op_e       : resolve operation encoding (NOP, BR, CALL, RET)
//   - COND_*     : branch condition encodings
//   - state_e    : two-state handshake FSM encoding
//   - eval_cond  : branch condition evaluation over ALU flags {Z,V,N}
// -----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_BR   = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    localparam logic [2:0] COND_EQ  = 3'b000;
    localparam logic [2:0] COND_LT  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_OV  = 3'b011;
    localparam logic [2:0] COND_NE  = 3'b100;
    localparam logic [2:0] COND_GEQ = 3'b101;
    localparam logic [2:0] COND_LEQ = 3'b110;
    localparam logic [2:0] COND_T   = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // flags is packed as {Z, V, N}.
    function automatic logic eval_cond(input logic [2:0] cond, input logic [2:0] flags);
        logic z;
        logic v;
        logic n;
        logic res;
        z = flags[2];
        v = flags[1];
        n = flags[0];
        case (cond)
            COND_EQ:  res = z;
            COND_LT:  res = n & ~v;
            COND_GT:  res = ~z & ~n & ~v;
            COND_OV:  res = v;
            COND_NE:  res = ~z;
            COND_GEQ: res = v | ~n;
            COND_LEQ: res = z | (n & ~v);
            COND_T:   res = 1'b1;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// -----------------------------------------------------------------------------
// pc_ras
// Circular return-address stack. A push when full overwrites the oldest entry
// and keeps the occupancy saturated at RAS_DEPTH. Entry storage is not reset;
// top is only meaningful while count is non-zero.
// Ports:
//   clk, rst          clock, async active-high reset (pointer/count only)
//   push, push_data   write push_data at the stack top
//   pop               remove the top entry (ignored when empty)
//   top               current top entry
//   full, empty       occupancy status from the registered count
//   count             number of valid entries (0..RAS_DEPTH)
// -----------------------------------------------------------------------------
module pc_ras #(
    parameter int PC_W      = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [PC_W-1:0]              push_data,
    output logic [PC_W-1:0]              top,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(RAS_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_r;     // next free slot
    logic [CNT_W-1:0] count_r;

    // Entry storage; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy; the pointer wraps so a full push replaces the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r   <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (push) begin
            ptr_r <= ptr_r + PTR_W'(1);
            if (count_r != DEPTH_C) begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (pop && (count_r != {CNT_W{1'b0}})) begin
            ptr_r   <= ptr_r - PTR_W'(1);
            count_r <= count_r - CNT_W'(1);
        end
    end

    assign top   = mem_r[ptr_r - PTR_W'(1)];
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/pc_redirect_ras.sv
// -----------------------------------------------------------------------------
// pc_redirect_ras
// Resolves BR / CALL / RET requests into a registered fetch redirect and
// maintains a return-address stack. One request is held at a time: accepted
// in IDLE, result presented in HOLD until the consumer takes it or a flush
// discards it.
// Ports:
//   clk, rst                    clock, async active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_op, branch_cond, flags  operation, condition select, ALU flags {Z,V,N}
//   pc_in, sign_ext, call_imm   resolving PC, branch offset, call target bits
//   flush                       drop pending redirect / block acceptance
//   redir_valid/redir_ready     result handshake
//   redir_taken, redir_pc       redirect decision and next fetch PC
//   update_done                 1-cycle pulse when a CALL/RET result is taken
//   ras_full, ras_empty         stack occupancy
//   ras_ovf, ras_unf            sticky overflow / underflow flags
// -----------------------------------------------------------------------------
module pc_redirect_ras
    import pc_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int IMM_W     = 12,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [2:0]        branch_cond,
    input  logic [2:0]        flags,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [PC_W-1:0]   sign_ext,
    input  logic [IMM_W-1:0]  call_imm,
    input  logic              flush,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic              redir_taken,
    output logic [PC_W-1:0]   redir_pc,
    output logic              update_done,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    state_e            state_r;
    op_e               held_op_r;
    logic              req_ready_r;
    logic              redir_valid_r;
    logic              redir_taken_r;
    logic [PC_W-1:0]   redir_pc_r;
    logic              update_done_r;
    logic              ras_ovf_r;
    logic              ras_unf_r;

    op_e               op_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              unf_s;
    logic              ovf_s;
    logic              next_taken_s;
    logic [PC_W-1:0]   next_pc_s;
    logic [PC_W-1:0]   pc_inc_s;
    logic [PC_W-1:0]   ras_top_s;
    logic              ras_full_s;
    logic              ras_empty_s;
    logic [CNT_W-1:0]  ras_count_s;

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top       (ras_top_s),
        .full      (ras_full_s),
        .empty     (ras_empty_s),
        .count     (ras_count_s)
    );

    // Acceptance, stack control and next-result computation.
    always_comb begin
        op_s         = op_e'(req_op);
        pc_inc_s     = pc_in + PC_W'(1);
        accept_s     = (state_r == ST_IDLE) && req_valid && !flush && (op_s != OP_NOP);
        push_s       = accept_s && (op_s == OP_CALL);
        pop_s        = accept_s && (op_s == OP_RET) && !ras_empty_s;
        unf_s        = accept_s && (op_s == OP_RET) && ras_empty_s;
        ovf_s        = push_s && ras_full_s;
        next_taken_s = 1'b0;
        next_pc_s    = pc_inc_s;
        case (op_s)
            OP_BR: begin
                next_taken_s = eval_cond(branch_cond, flags);
                if (next_taken_s) begin
                    next_pc_s = pc_in + sign_ext;
                end else begin
                    next_pc_s = pc_inc_s;
                end
            end
            OP_CALL: begin
                next_taken_s = 1'b1;
                next_pc_s    = {pc_in[PC_W-1:IMM_W], call_imm};
            end
            OP_RET: begin
                // Empty stack: fall through sequentially instead of redirecting.
                if (!ras_empty_s) begin
                    next_taken_s = 1'b1;
                    next_pc_s    = ras_top_s;
                end else begin
                    next_taken_s = 1'b0;
                    next_pc_s    = pc_inc_s;
                end
            end
            default: begin
                next_taken_s = 1'b0;
                next_pc_s    = pc_inc_s;
            end
        endcase
    end

    // Handshake FSM with registered outputs and sticky stack flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            held_op_r     <= OP_NOP;
            req_ready_r   <= 1'b1;
            redir_valid_r <= 1'b0;
            redir_taken_r <= 1'b0;
            redir_pc_r    <= {PC_W{1'b0}};
            update_done_r <= 1'b0;
            ras_ovf_r     <= 1'b0;
            ras_unf_r     <= 1'b0;
        end else begin
            update_done_r <= 1'b0;
            if (ovf_s) begin
                ras_ovf_r <= 1'b1;
            end
            if (unf_s) begin
                ras_unf_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r       <= ST_HOLD;
                        held_op_r     <= op_s;
                        req_ready_r   <= 1'b0;
                        redir_valid_r <= 1'b1;
                        redir_taken_r <= next_taken_s;
                        redir_pc_r    <= next_pc_s;
                    end
                end
                ST_HOLD: begin
                    // Flush wins over a simultaneous accept and suppresses update_done.
                    if (flush) begin
                        state_r       <= ST_IDLE;
                        req_ready_r   <= 1'b1;
                        redir_valid_r <= 1'b0;
                    end else if (redir_ready) begin
                        state_r       <= ST_IDLE;
                        req_ready_r   <= 1'b1;
                        redir_valid_r <= 1'b0;
                        update_done_r <= (held_op_r == OP_CALL) || (held_op_r == OP_RET);
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    req_ready_r   <= 1'b1;
                    redir_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign redir_valid = redir_valid_r;
    assign redir_taken = redir_taken_r;
    assign redir_pc    = redir_pc_r;
    assign update_done = update_done_r;
    assign ras_ovf     = ras_ovf_r;
    assign ras_unf     = ras_unf_r;
    assign ras_full    = (ras_count_s == CNT_W'(RAS_DEPTH));
    assign ras_empty   = (ras_count_s == {CNT_W{1'b0}});

endmodule

// File: tb/tb_pc_redirect_ras.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_ras
// Directed self-checking bench for pc_redirect_ras (PC_W=16, IMM_W=12,
// RAS_DEPTH=8). Inputs change 1 time unit after the rising edge and outputs
// are sampled at that same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_pc_redirect_ras;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  branch_cond;
    logic [2:0]  flags;
    logic [15:0] pc_in;
    logic [15:0] sign_ext;
    logic [11:0] call_imm;
    logic        flush;
    logic        redir_valid;
    logic        redir_ready;
    logic        redir_taken;
    logic [15:0] redir_pc;
    logic        update_done;
    logic        ras_full;
    logic        ras_empty;
    logic        ras_ovf;
    logic        ras_unf;

    int total;
    int bad;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] BR   = 2'b01;
    localparam logic [1:0] CALL = 2'b10;
    localparam logic [1:0] RET  = 2'b11;

    pc_redirect_ras #(
        .PC_W      (16),
        .IMM_W     (12),
        .RAS_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .branch_cond (branch_cond),
        .flags       (flags),
        .pc_in       (pc_in),
        .sign_ext    (sign_ext),
        .call_imm    (call_imm),
        .flush       (flush),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_taken (redir_taken),
        .redir_pc    (redir_pc),
        .update_done (update_done),
        .ras_full    (ras_full),
        .ras_empty   (ras_empty),
        .ras_ovf     (ras_ovf),
        .ras_unf     (ras_unf)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one edge, then leave the bus idle.
    task automatic issue(input logic [1:0] op, input logic [2:0] cond, input logic [2:0] fl,
                         input logic [15:0] pc, input logic [15:0] se, input logic [11:0] imm);
        req_valid   = 1'b1;
        req_op      = op;
        branch_cond = cond;
        flags       = fl;
        pc_in       = pc;
        sign_ext    = se;
        call_imm    = imm;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = NOP;
    endtask

    // Accept the held result on one edge.
    task automatic take_result();
        redir_ready = 1'b1;
        @(posedge clk);
        #1;
        redir_ready = 1'b0;
    endtask

    logic [2:0]  fpat    [4];
    logic [7:0]  exp_tbl [4];
    logic [15:0] hold_pc;

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_op      = NOP;
        branch_cond = 3'b000;
        flags       = 3'b000;
        pc_in       = 16'h0000;
        sign_ext    = 16'h0000;
        call_imm    = 12'h000;
        flush       = 1'b0;
        redir_ready = 1'b0;

        // Condition truth per flag pattern {Z,V,N}; bit index = branch_cond.
        fpat[0] = 3'b100; exp_tbl[0] = 8'b1110_0001;
        fpat[1] = 3'b001; exp_tbl[1] = 8'b1101_0010;
        fpat[2] = 3'b000; exp_tbl[2] = 8'b1011_0100;
        fpat[3] = 3'b011; exp_tbl[3] = 8'b1011_1000;

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(redir_valid), 32'd0);
        chk("rst_taken", 32'(redir_taken), 32'd0);
        chk("rst_pc", 32'(redir_pc), 32'h0);
        chk("rst_upd", 32'(update_done), 32'd0);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        chk("rst_full", 32'(ras_full), 32'd0);
        chk("rst_ovf", 32'(ras_ovf), 32'd0);
        chk("rst_unf", 32'(ras_unf), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // BR EQ taken with negative offset.
        issue(BR, 3'b000, 3'b100, 16'h0010, 16'hFFFC, 12'h000);
        chk("breq_valid", 32'(redir_valid), 32'd1);
        chk("breq_taken", 32'(redir_taken), 32'd1);
        chk("breq_pc", 32'(redir_pc), 32'h000C);
        chk("breq_ready", 32'(req_ready), 32'd0);
        take_result();
        chk("breq_upd", 32'(update_done), 32'd0);
        chk("breq_idle", 32'(req_ready), 32'd1);

        // BR GT not taken.
        issue(BR, 3'b010, 3'b001, 16'h0020, 16'h0040, 12'h000);
        chk("brgt_taken", 32'(redir_taken), 32'd0);
        chk("brgt_pc", 32'(redir_pc), 32'h0021);
        take_result();

        // Target arithmetic wraps modulo 2^16.
        issue(BR, 3'b111, 3'b000, 16'hFFF0, 16'h0020, 12'h000);
        chk("brwrap_pc", 32'(redir_pc), 32'h0010);
        take_result();

        // All conditions against several flag patterns.
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                issue(BR, 3'(c), fpat[k], 16'h0040, 16'h0008, 12'h000);
                chk($sformatf("cond%0d_f%0d_taken", c, k), 32'(redir_taken), 32'(exp_tbl[k][c]));
                chk($sformatf("cond%0d_f%0d_pc", c, k), 32'(redir_pc),
                    exp_tbl[k][c] ? 32'h0048 : 32'h0041);
                take_result();
            end
        end

        // CALL then RET.
        issue(CALL, 3'b000, 3'b000, 16'h3005, 16'h0000, 12'h0AB);
        chk("call_pc", 32'(redir_pc), 32'h30AB);
        chk("call_taken", 32'(redir_taken), 32'd1);
        chk("call_empty", 32'(ras_empty), 32'd0);
        chk("call_upd_hold", 32'(update_done), 32'd0);
        take_result();
        chk("call_upd", 32'(update_done), 32'd1);
        @(posedge clk);
        #1;
        chk("call_upd_once", 32'(update_done), 32'd0);
        issue(RET, 3'b000, 3'b000, 16'h5000, 16'h0000, 12'h000);
        chk("ret_pc", 32'(redir_pc), 32'h3006);
        chk("ret_taken", 32'(redir_taken), 32'd1);
        chk("ret_empty", 32'(ras_empty), 32'd1);
        take_result();
        chk("ret_upd", 32'(update_done), 32'd1);

        // Stall: outputs held while the consumer is not ready, inputs wiggling.
        issue(BR, 3'b111, 3'b000, 16'h0200, 16'h0010, 12'h000);
        hold_pc = 16'h0210;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_op    = CALL;
            pc_in     = 16'(16'h0AA0 + 16'(i));
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", i), 32'(redir_valid), 32'd1);
            chk($sformatf("stall%0d_pc", i), 32'(redir_pc), 32'(hold_pc));
            chk($sformatf("stall%0d_ready", i), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        req_op    = NOP;
        chk("stall_empty", 32'(ras_empty), 32'd1);
        take_result();

        // Nine CALLs into an eight-deep stack.
        for (int i = 0; i < 9; i++) begin
            issue(CALL, 3'b000, 3'b000, 16'(16'h1000 + 16'(i * 16)), 16'h0000, 12'h000);
            if (i == 7) begin
                chk("ovf_full8", 32'(ras_full), 32'd1);
                chk("ovf_clear8", 32'(ras_ovf), 32'd0);
            end
            take_result();
        end
        chk("ovf_set", 32'(ras_ovf), 32'd1);
        chk("ovf_full", 32'(ras_full), 32'd1);

        // Eight RETs return the newest eight, newest first.
        for (int i = 8; i >= 1; i--) begin
            issue(RET, 3'b000, 3'b000, 16'h7000, 16'h0000, 12'h000);
            chk($sformatf("pop%0d_pc", i), 32'(redir_pc), 32'(16'h1001 + 16'(i * 16)));
            chk($sformatf("pop%0d_taken", i), 32'(redir_taken), 32'd1);
            take_result();
        end
        chk("pop_empty", 32'(ras_empty), 32'd1);
        chk("pop_unf_clear", 32'(ras_unf), 32'd0);

        // Ninth RET underflows.
        issue(RET, 3'b000, 3'b000, 16'h7000, 16'h0000, 12'h000);
        chk("unf_taken", 32'(redir_taken), 32'd0);
        chk("unf_pc", 32'(redir_pc), 32'h7001);
        chk("unf_set", 32'(ras_unf), 32'd1);
        take_result();
        chk("unf_upd", 32'(update_done), 32'd1);

        // Flush in HOLD: back to IDLE, no pulse, push kept.
        issue(CALL, 3'b000, 3'b000, 16'h2000, 16'h0000, 12'h111);
        flush       = 1'b1;
        redir_ready = 1'b1;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        redir_ready = 1'b0;
        chk("flush_valid", 32'(redir_valid), 32'd0);
        chk("flush_ready", 32'(req_ready), 32'd1);
        chk("flush_upd", 32'(update_done), 32'd0);
        chk("flush_kept", 32'(ras_empty), 32'd0);
        chk("flush_ovf_sticky", 32'(ras_ovf), 32'd1);
        issue(RET, 3'b000, 3'b000, 16'h4000, 16'h0000, 12'h000);
        chk("flush_ret_pc", 32'(redir_pc), 32'h2001);
        take_result();

        // Flush in IDLE blocks acceptance; NOP is ignored.
        flush = 1'b1;
        issue(BR, 3'b111, 3'b000, 16'h0300, 16'h0004, 12'h000);
        flush = 1'b0;
        chk("iflush_valid", 32'(redir_valid), 32'd0);
        chk("iflush_ready", 32'(req_ready), 32'd1);
        issue(NOP, 3'b111, 3'b000, 16'h0300, 16'h0004, 12'h000);
        chk("nop_valid", 32'(redir_valid), 32'd0);
        chk("nop_ready", 32'(req_ready), 32'd1);

        // Asynchronous reset in HOLD clears everything at once.
        issue(CALL, 3'b000, 3'b000, 16'h6000, 16'h0000, 12'h222);
        chk("prerst_valid", 32'(redir_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(redir_valid), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_pc", 32'(redir_pc), 32'h0);
        chk("arst_taken", 32'(redir_taken), 32'd0);
        chk("arst_empty", 32'(ras_empty), 32'd1);
        chk("arst_ovf", 32'(ras_ovf), 32'd0);
        chk("arst_unf", 32'(ras_unf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_upd", 32'(update_done), 32'd0);
        chk("arst_idle_valid", 32'(redir_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
